dekatron_step_sequencer: RTL and testbench

DEKATRON_STEP_SEQUENCER -- requirements
Module: dekatron_step_sequencer

---
 rtl/dekatron_step_sequencer.sv | 133 +++++++++++++
 tb/tb_dekatron_step_sequencer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/dekatron_step_sequencer.sv
// Dekatron step sequencer: drives P1 (forward) or P2 (backward) pulse trains per digit step and tracks the digit.
// Optional macro DEKATRON_CARRY_EN enables one-cycle carry/borrow flags on 9->0 / 0->9 wraps.
module dekatron_step_sequencer #(
  parameter int CATH_PER_DIGIT = 3,
  parameter int GAP_LEN        = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_dir,
  input  logic [3:0] req_count,
  output logic       P1,
  output logic       P2,
  output logic [3:0] position,
  output logic       busy,
  output logic       done,
  output logic       carry,
  output logic       borrow
);
  localparam int CW = (CATH_PER_DIGIT > 1) ? $clog2(CATH_PER_DIGIT) : 1;

  typedef enum logic [1:0] {IDLE, PULSE, GAP, DONE} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   pcnt_q, pcnt_d;
  logic [3:0]      gcnt_q, gcnt_d;
  logic [3:0]      steps_q, steps_d;
  logic [3:0]      pos_q, pos_d;
  logic            dir_q, dir_d;
  logic            p1_q, p1_d, p2_q, p2_d;
  logic            done_q, done_d, carry_q, carry_d, borrow_q, borrow_d;
  logic [3:0]      pos_next;

  assign pos_next = dir_q ? ((pos_q == 4'd0) ? 4'd9 : pos_q - 4'd1)
                          : ((pos_q == 4'd9) ? 4'd0 : pos_q + 4'd1);

  always_comb begin
    state_d  = state_q;
    pcnt_d   = pcnt_q;
    gcnt_d   = gcnt_q;
    steps_d  = steps_q;
    pos_d    = pos_q;
    dir_d    = dir_q;
    p1_d     = 1'b0;
    p2_d     = 1'b0;
    done_d   = 1'b0;
    carry_d  = 1'b0;
    borrow_d = 1'b0;
    case (state_q)
      IDLE: if (req_valid) begin
        dir_d   = req_dir;
        steps_d = req_count;
        pcnt_d  = '0;
        if (req_count == 4'd0) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          state_d = PULSE;
          p1_d    = ~req_dir;
          p2_d    = req_dir;
        end
      end
      PULSE: if (pcnt_q == CW'(CATH_PER_DIGIT - 1)) begin
        // last pulse cycle of this digit: the tube has settled on the next digit
        state_d = GAP;
        gcnt_d  = '0;
        steps_d = steps_q - 4'd1;
        pos_d   = pos_next;
`ifdef DEKATRON_CARRY_EN
        carry_d  = ~dir_q & (pos_q == 4'd9);
        borrow_d = dir_q & (pos_q == 4'd0);
`endif
      end else begin
        pcnt_d = pcnt_q + 1'b1;
        p1_d   = ~dir_q;
        p2_d   = dir_q;
      end
      GAP: if (gcnt_q == 4'(GAP_LEN - 1)) begin
        if (steps_q == 4'd0) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          state_d = PULSE;
          pcnt_d  = '0;
          p1_d    = ~dir_q;
          p2_d    = dir_q;
        end
      end else begin
        gcnt_d = gcnt_q + 4'd1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      pcnt_q   <= '0;
      gcnt_q   <= '0;
      steps_q  <= '0;
      pos_q    <= '0;
      dir_q    <= 1'b0;
      p1_q     <= 1'b0;
      p2_q     <= 1'b0;
      done_q   <= 1'b0;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pcnt_q   <= pcnt_d;
      gcnt_q   <= gcnt_d;
      steps_q  <= steps_d;
      pos_q    <= pos_d;
      dir_q    <= dir_d;
      p1_q     <= p1_d;
      p2_q     <= p2_d;
      done_q   <= done_d;
      carry_q  <= carry_d;
      borrow_q <= borrow_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign P1        = p1_q;
  assign P2        = p2_q;
  assign position  = pos_q;
  assign done      = done_q;
  assign carry     = carry_q;
  assign borrow    = borrow_q;
endmodule

// File: tb/tb_dekatron_step_sequencer.sv
// Bench for dekatron_step_sequencer: per-cycle check against a timing model plus directed literal checks.
module tb_dekatron_step_sequencer;
  localparam int C = 3;
  localparam int G = 2;
  localparam int S = C + G;
`ifdef DEKATRON_CARRY_EN
  localparam int CARRY_ON = 1;
`else
  localparam int CARRY_ON = 0;
`endif

  logic       clk = 1'b0;
  logic       reset, req_valid, req_dir;
  logic [3:0] req_count;
  logic       req_ready, P1, P2, busy, done, carry, borrow;
  logic [3:0] position;

  dekatron_step_sequencer #(.CATH_PER_DIGIT(C), .GAP_LEN(G)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_dir(req_dir), .req_count(req_count), .P1(P1), .P2(P2),
    .position(position), .busy(busy), .done(done), .carry(carry), .borrow(borrow)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic int posat(input int pos0, input bit dir, input int d);
    return dir ? (pos0 + 10 - (d % 10)) % 10 : (pos0 + d) % 10;
  endfunction

  // model: k = cycles since acceptance; transaction occupies k = 1 .. n+1 (n = count*S)
  bit m_act = 0, m_dir = 0, chk_en = 0;
  int m_k = 0, m_n = 0, m_cnt = 0, m_pos0 = 0, m_pos = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_act  <= 0;
      m_pos  <= 0;
      chk_en <= 1;
    end else if (m_act) begin
      m_k <= m_k + 1;
      if (m_k + 1 > m_n + 1) begin
        m_act <= 0;
        m_pos <= posat(m_pos0, m_dir, m_cnt);
      end
    end else if (req_valid) begin
      m_act  <= 1;
      m_k    <= 1;
      m_cnt  <= int'(req_count);
      m_dir  <= req_dir;
      m_pos0 <= m_pos;
      m_n    <= int'(req_count) * S;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      int e_pos, d;
      bit e_p1, e_p2, e_done, e_busy, e_rdy, e_c, e_b, pulse;
      e_p1 = 0; e_p2 = 0; e_done = 0; e_c = 0; e_b = 0;
      if (!m_act) begin
        e_busy = 0; e_rdy = 1; e_pos = m_pos;
      end else begin
        e_busy = 1; e_rdy = 0; d = 0;
        for (int j = 0; j < m_cnt; j++) begin
          if (j * S + C + 1 <= m_k) d++;
          if (j * S + C + 1 == m_k) begin
            if (!m_dir && posat(m_pos0, m_dir, j) == 9) e_c = 1;
            if (m_dir && posat(m_pos0, m_dir, j) == 0) e_b = 1;
          end
        end
        e_pos  = posat(m_pos0, m_dir, d);
        pulse  = (m_k <= m_n) && (((m_k - 1) % S) < C);
        e_p1   = pulse && !m_dir;
        e_p2   = pulse && m_dir;
        e_done = (m_k == m_n + 1);
      end
      if (CARRY_ON == 0) begin e_c = 0; e_b = 0; end
      chk("m_P1", 32'(P1), 32'(e_p1));
      chk("m_P2", 32'(P2), 32'(e_p2));
      chk("m_done", 32'(done), 32'(e_done));
      chk("m_busy", 32'(busy), 32'(e_busy));
      chk("m_ready", 32'(req_ready), 32'(e_rdy));
      chk("m_pos", 32'(position), 32'(e_pos));
      chk("m_carry", 32'(carry), 32'(e_c));
      chk("m_borrow", 32'(borrow), 32'(e_b));
    end
  end

  task automatic issue(input bit dir, input logic [3:0] cnt);
    @(negedge clk);
    for (int i = 0; i < 100 && req_ready !== 1'b1; i++) @(negedge clk);
    if (req_ready !== 1'b1) chk("ready_timeout", 32'(req_ready), 32'd1);
    req_valid = 1; req_dir = dir; req_count = cnt;
    @(posedge clk);
    #2 req_valid = 0;
  endtask

  logic [16:0] p1m, p2m, dm;
  int n1, n2, nb, nc;

  initial begin
    reset = 1; req_valid = 0; req_dir = 0; req_count = 0;
    repeat (2) @(posedge clk);
    #2 reset = 0;
    repeat (5) @(negedge clk);
    chk("idle_pos", 32'(position), 32'd0);
    chk("idle_p1p2", 32'({P1, P2}), 32'd0);
    chk("idle_ready", 32'(req_ready), 32'd1);
    chk("idle_busy", 32'(busy), 32'd0);

    // forward 3; junk request held while busy must be ignored
    issue(0, 4'd3);
    req_valid = 1; req_dir = 1; req_count = 4'd7;
    p1m = '0; p2m = '0; dm = '0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      p1m[k] = P1; p2m[k] = P2; dm[k] = done;
      if (k == 10) req_valid = 0;
    end
    chk("fwd3_p1_mask", 32'(p1m), 32'h039CE);
    chk("fwd3_p2_mask", 32'(p2m), 32'h0);
    chk("fwd3_done_mask", 32'(dm), 32'h10000);
    chk("fwd3_pos", 32'(position), 32'd3);

    // reset beats a simultaneous request
    @(negedge clk);
    reset = 1; req_valid = 1; req_dir = 0; req_count = 4'd5;
    @(posedge clk);
    #2 reset = 0; req_valid = 0;
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_req_busy", 32'(busy), 32'd0);
    chk("rst_req_pos", 32'(position), 32'd0);

    // backward 1 from 0
    issue(1, 4'd1);
    n1 = 0; n2 = 0; nb = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      n1 += int'(P1); n2 += int'(P2); nb += int'(borrow);
      if (k == 6) chk("bwd1_done", 32'(done), 32'd1);
    end
    chk("bwd1_p2_cycles", 32'(n2), 32'd3);
    chk("bwd1_p1_cycles", 32'(n1), 32'd0);
    chk("bwd1_borrow", 32'(nb), 32'(CARRY_ON));
    chk("bwd1_pos", 32'(position), 32'd9);

    // 9 -> 8, then forward 4 through the wrap
    issue(1, 4'd1);
    repeat (6) @(negedge clk);
    chk("to8_pos", 32'(position), 32'd8);
    issue(0, 4'd4);
    nc = 0;
    for (int k = 1; k <= 21; k++) begin
      @(negedge clk);
      nc += int'(carry);
      if (carry === 1'b1) chk("carry_at_wrap", 32'(position), 32'd0);
    end
    chk("fwd4_carry", 32'(nc), 32'(CARRY_ON));
    chk("fwd4_pos", 32'(position), 32'd2);

    // zero count
    issue(0, 4'd0);
    @(negedge clk);
    chk("zero_done", 32'(done), 32'd1);
    chk("zero_p1p2", 32'({P1, P2}), 32'd0);
    chk("zero_pos", 32'(position), 32'd2);

    // reset at cycle 4 of forward 5, then a normal request
    issue(0, 4'd5);
    for (int k = 1; k <= 4; k++) @(negedge clk);
    reset = 1;
    @(posedge clk);
    #2 reset = 0;
    @(negedge clk);
    chk("abort_p1", 32'(P1), 32'd0);
    chk("abort_pos", 32'(position), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_ready", 32'(req_ready), 32'd1);
    issue(0, 4'd2);
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      if (k == 11) chk("post_abort_done", 32'(done), 32'd1);
    end
    chk("post_abort_pos", 32'(position), 32'd2);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
